pipeline_hazard_ctrl: RTL

Front-end sequencing controller for the five-stage MIPS pipeline. It gates PC and IF/ID writes, forces bubbles into the ID/EXE register, and flushes IF/ID on taken branches. It also owns the launch/wait handshake for the multi-cycle multiply/divide unit (MDU). It sits beside the ID stage, takes rs/rt from decode and mem_read/rt from the ID/EXE outputs, and drives the enable/clear inputs of the PC, IF/ID and ID/EXE control fields.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/load_use_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline front-end control.
// Holds the hazard FSM state enum and register-index constants.
package pipeline_pkg;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    HALT_ERR = 2'd2
  } hz_state_t;
endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: a load in ID/EXE whose destination
// is a source of the ID instruction. Ports: ID rs/rt/uses_rt, EX mem_read/rt.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rt,
  output logic              o_load_use
);
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_ex_rt == i_id_rs);
  assign w_rt_hit = i_id_uses_rt && (i_ex_rt == i_id_rt);

  // $zero is never a real dependency.
  assign o_load_use = i_ex_mem_read && (i_ex_rt != REG_ZERO)
                   && (w_rs_hit || w_rt_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard/sequencing controller: PC/IF-ID enables, bubbles,
// branch flush, MDU launch/wait handshake, timeout error, stall counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              branch_taken,
  input  logic              mdu_start,
  input  logic              mdu_done,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_exe_bubble,
  output logic              mdu_go,
  output logic              err,
  output logic [CNT_W-1:0]  stall_cycles
);
  localparam int WCW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(MDU_TIMEOUT - 1);

  hz_state_t        r_state;
  hz_state_t        w_next;
  logic [WCW-1:0]   r_wait_cnt;
  logic [CNT_W-1:0] r_stall;
  logic             w_load_use;
  logic             w_wait_clr;
  logic             w_wait_inc;

  load_use_detect u_lud (
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_uses_rt  (id_uses_rt),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rt       (ex_rt),
    .o_load_use    (w_load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    mdu_go        = 1'b0;
    err           = 1'b0;
    w_wait_clr    = 1'b0;
    w_wait_inc    = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_load_use) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_exe_bubble = 1'b1;
        end else if (mdu_start) begin
          mdu_go        = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_exe_bubble = 1'b1;
          w_wait_clr    = 1'b1;
          w_next        = MDU_WAIT;
        end else if (branch_taken) begin
          if_id_flush   = 1'b1;
        end
      end
      MDU_WAIT: begin
        // Done wins over timeout: release lets the MDU op into ID/EXE.
        if (mdu_done) begin
          w_next        = RUN;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_exe_bubble = 1'b1;
          w_wait_inc    = 1'b1;
          if (r_wait_cnt == W_LAST) begin
            w_next = HALT_ERR;
          end
        end
      end
      HALT_ERR: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_exe_bubble = 1'b1;
        err           = 1'b1;
      end
      default: begin
        w_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_wait_clr) begin
      r_wait_cnt <= '0;
    end else if (w_wait_inc) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (!pc_write && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
endmodule
